// File: rtl/pio_irq_service_master_pkg.sv
// Shared definitions for the PIO irq service master.
// Register offsets, FSM states and the registered bus command bundle.
package pio_irq_service_master_pkg;

    localparam logic [1:0] REG_DATA = 2'd0;
    localparam logic [1:0] REG_MASK = 2'd2;
    localparam logic [1:0] REG_EDGE = 2'd3;

    typedef enum logic [2:0] {
        S_MASK,
        S_IDLE,
        S_RDCAP,
        S_WCAP,
        S_RDLVL,
        S_WLVL,
        S_CLR,
        S_PUSH
    } state_e;

    typedef struct packed {
        logic [1:0]  addr;
        logic        cs;
        logic        write_n;
        logic [31:0] wdata;
    } avm_cmd_t;

    localparam avm_cmd_t CMD_NOP = '{2'd0, 1'b0, 1'b1, 32'd0};

endpackage

// File: rtl/pio_irq_service_master_if.sv
// Avalon-MM link between the service master and the PIO s1 slave.
// The master drives the access strobes; the PIO returns data and irq.
interface pio_irq_service_master_if;

    logic [1:0]  avm_address;
    logic        avm_chipselect;
    logic        avm_write_n;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_irq;

    modport master (
        output avm_address,
        output avm_chipselect,
        output avm_write_n,
        output avm_writedata,
        input  avm_readdata,
        input  avm_irq
    );

    modport slave (
        input  avm_address,
        input  avm_chipselect,
        input  avm_write_n,
        input  avm_writedata,
        output avm_readdata,
        output avm_irq
    );

endinterface

// File: rtl/pio_evt_fifo.sv
// Synchronous first-word fall-through event FIFO.
// Head entry is visible on rdata whenever the FIFO is not empty.
module pio_evt_fifo #(
    parameter int W     = 20,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          push_ok;
    logic          pop_ok;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;
    assign rdata = mem_q[rd_q];

    always_comb begin
        push_ok = push && !full;
        pop_ok  = pop && !empty;
        wr_d    = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d    = pop_ok ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q;
        if (push_ok && !pop_ok) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!push_ok && pop_ok) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= wdata;
        end
    end

endmodule

// File: rtl/pio_irq_service_master.sv
// Services an edge-capture PIO without a CPU: programs the irq mask,
// reads edge_capture and data on irq, clears the capture, queues events.
module pio_irq_service_master
    import pio_irq_service_master_pkg::*;
#(
    parameter int DATA_W       = 10,
    parameter int FIFO_DEPTH   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [DATA_W-1:0]             mask_cfg,
    input  logic                          mask_load,
    pio_irq_service_master_if.master      avm,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [DATA_W-1:0]             evt_capture,
    output logic [DATA_W-1:0]             evt_level,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          busy
);

    localparam logic [1:0] LAST = 2'(READ_LATENCY - 1);

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              pending_q, pending_d;
    logic              irq_q;
    logic [DATA_W-1:0] cap_q, cap_d;
    logic [DATA_W-1:0] lvl_q, lvl_d;
    avm_cmd_t          cmd_q, cmd_d;
    logic              push;
    logic              lat_done;
    logic              fifo_full;
    logic              fifo_empty;
    logic [2*DATA_W-1:0] fifo_rdata;
    logic              unused_rd;

    assign unused_rd = ^avm.avm_readdata[31:DATA_W];
    assign lat_done  = (cnt_q == LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_MASK;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_MASK:  state_d = S_IDLE;
            S_IDLE: begin
                if (pending_q) begin
                    state_d = S_MASK;
                end else if (irq_q && !fifo_full) begin
                    state_d = S_RDCAP;
                end
            end
            S_RDCAP: state_d = S_WCAP;
            S_WCAP:  if (lat_done) state_d = S_RDLVL;
            S_RDLVL: state_d = S_WLVL;
            S_WLVL:  if (lat_done) state_d = S_CLR;
            S_CLR:   state_d = S_PUSH;
            S_PUSH:  state_d = S_IDLE;
        endcase
    end

    // Reads and the clear are aligned with their state; the mask write
    // leaves S_MASK so the reset state itself presents an idle bus.
    always_comb begin
        cmd_d = CMD_NOP;
        if (state_q == S_MASK) begin
            cmd_d = '{REG_MASK, 1'b1, 1'b0, 32'(mask_cfg)};
        end else begin
            unique case (state_d)
                S_RDCAP: cmd_d = '{REG_EDGE, 1'b1, 1'b1, 32'd0};
                S_RDLVL: cmd_d = '{REG_DATA, 1'b1, 1'b1, 32'd0};
                S_CLR:   cmd_d = '{REG_EDGE, 1'b1, 1'b0, 32'({DATA_W{1'b1}})};
                default: cmd_d = CMD_NOP;
            endcase
        end

        cnt_d = (state_d == state_q) ? cnt_q + 2'd1 : 2'd0;

        pending_d = pending_q | mask_load;
        if (state_d == S_MASK && state_q != S_MASK) begin
            pending_d = 1'b0;
        end

        cap_d = cap_q;
        lvl_d = lvl_q;
        if (state_q == S_WCAP && lat_done) begin
            cap_d = avm.avm_readdata[DATA_W-1:0];
        end
        if (state_q == S_WLVL && lat_done) begin
            lvl_d = avm.avm_readdata[DATA_W-1:0];
        end

        push = (state_q == S_PUSH) && (cap_q != '0);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q     <= '0;
            pending_q <= 1'b0;
            irq_q     <= 1'b0;
            cap_q     <= '0;
            lvl_q     <= '0;
            cmd_q     <= CMD_NOP;
        end else begin
            cnt_q     <= cnt_d;
            pending_q <= pending_d;
            irq_q     <= avm.avm_irq;
            cap_q     <= cap_d;
            lvl_q     <= lvl_d;
            cmd_q     <= cmd_d;
        end
    end

    assign avm.avm_address    = cmd_q.addr;
    assign avm.avm_chipselect = cmd_q.cs;
    assign avm.avm_write_n    = cmd_q.write_n;
    assign avm.avm_writedata  = cmd_q.wdata;

    pio_evt_fifo #(
        .W     (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .wdata   ({cap_q, lvl_q}),
        .pop     (evt_ready),
        .rdata   (fifo_rdata),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (evt_count)
    );

    assign evt_valid   = !fifo_empty;
    assign evt_capture = fifo_rdata[2*DATA_W-1:DATA_W];
    assign evt_level   = fifo_rdata[DATA_W-1:0];
    assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_pio_irq_service_master.sv
// Bench for pio_irq_service_master with a behavioural edge-capture PIO.
// Expected bus accesses and events are queued; a monitor checks them.
module tb_pio_irq_service_master;

    localparam int DW = 10;

    typedef struct {
        logic [1:0]  a;
        logic        wn;
        logic [31:0] d;
    } acc_t;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [DW-1:0] mask_cfg = '0;
    logic          mask_load = 1'b0;
    logic          evt_ready = 1'b0;
    logic          evt_valid;
    logic [DW-1:0] evt_capture;
    logic [DW-1:0] evt_level;
    logic [2:0]    evt_count;
    logic          busy;

    logic [DW-1:0] in_port = '0;
    logic [DW-1:0] in_d = '0;
    logic [DW-1:0] ec = '0;
    logic [DW-1:0] pmask = '0;
    logic [31:0]   rdata_r = '0;
    logic          irq_force = 1'b0;
    logic          model_clr = 1'b0;

    acc_t            exp_acc[$];
    logic [2*DW-1:0] exp_evt[$];
    acc_t            mon_a;
    logic [2*DW-1:0] mon_e;
    int              n_chk = 0;
    int              n_pass = 0;
    int              irq_at;
    int              lat;
    logic [DW-1:0]   v3 [5];

    always #5 clk = ~clk;

    pio_irq_service_master_if avm_if ();

    pio_irq_service_master #(
        .DATA_W       (DW),
        .FIFO_DEPTH   (4),
        .READ_LATENCY (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .mask_cfg    (mask_cfg),
        .mask_load   (mask_load),
        .avm         (avm_if.master),
        .evt_valid   (evt_valid),
        .evt_ready   (evt_ready),
        .evt_capture (evt_capture),
        .evt_level   (evt_level),
        .evt_count   (evt_count),
        .busy        (busy)
    );

    // Edge-capture PIO, rising edges, read latency 1, unaffected by reset_n
    always @(posedge clk) begin
        in_d <= in_port;
        if ((avm_if.avm_chipselect && !avm_if.avm_write_n &&
             avm_if.avm_address == 2'd3) || model_clr) begin
            ec <= '0;
        end else begin
            ec <= ec | (in_port & ~in_d);
        end
        if (avm_if.avm_chipselect && !avm_if.avm_write_n &&
            avm_if.avm_address == 2'd2) begin
            pmask <= avm_if.avm_writedata[DW-1:0];
        end
        if (avm_if.avm_chipselect && avm_if.avm_write_n) begin
            case (avm_if.avm_address)
                2'd0:    rdata_r <= 32'(in_port);
                2'd2:    rdata_r <= 32'(pmask);
                2'd3:    rdata_r <= 32'(ec);
                default: rdata_r <= 32'd0;
            endcase
        end
    end

    assign avm_if.avm_readdata = rdata_r;
    assign avm_if.avm_irq      = (|(ec & pmask)) | irq_force;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
        n_chk++;
        if (act === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic exp_a(input logic [1:0] a, input logic wn,
                         input logic [31:0] d);
        acc_t e;
        e.a  = a;
        e.wn = wn;
        e.d  = d;
        exp_acc.push_back(e);
    endtask

    task automatic exp_svc();
        exp_a(2'd3, 1'b1, 32'd0);
        exp_a(2'd0, 1'b1, 32'd0);
        exp_a(2'd3, 1'b0, 32'h3FF);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_cnt(input int c);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (int'(evt_count) == c) return;
        end
        chk("wait_count_timeout", 64'(evt_count), 64'(c));
    endtask

    task automatic wait_acc_empty();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_acc.size() == 0) return;
        end
        chk("acc_pending_timeout", 64'(exp_acc.size()), 64'd0);
    endtask

    task automatic wait_evt_empty();
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (exp_evt.size() == 0) return;
        end
        chk("evt_pending_timeout", 64'(exp_evt.size()), 64'd0);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (avm_if.avm_chipselect) begin
                if (exp_acc.size() == 0) begin
                    n_chk++;
                    $display("FAIL acc_unexpected: got addr %0d write_n %0b data %0h, expected no access",
                             avm_if.avm_address, avm_if.avm_write_n,
                             avm_if.avm_writedata);
                end else begin
                    mon_a = exp_acc.pop_front();
                    chk("acc",
                        {avm_if.avm_address, avm_if.avm_write_n,
                         avm_if.avm_write_n ? 32'd0 : avm_if.avm_writedata},
                        {mon_a.a, mon_a.wn, mon_a.d});
                end
            end
            if (evt_valid && evt_ready) begin
                if (exp_evt.size() == 0) begin
                    n_chk++;
                    $display("FAIL evt_unexpected: got cap %0h lvl %0h, expected no event",
                             evt_capture, evt_level);
                end else begin
                    mon_e = exp_evt.pop_front();
                    chk("evt", {evt_capture, evt_level}, mon_e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        v3[0] = 10'h001;
        v3[1] = 10'h002;
        v3[2] = 10'h200;
        v3[3] = 10'h0F0;
        v3[4] = 10'h155;

        // Reset state and initial mask write
        mask_cfg = 10'h3FF;
        exp_a(2'd2, 1'b0, 32'h3FF);
        @(negedge clk);
        chk("rst_cs", 64'(avm_if.avm_chipselect), 64'd0);
        chk("rst_wn", 64'(avm_if.avm_write_n), 64'd1);
        chk("rst_addr", 64'(avm_if.avm_address), 64'd0);
        chk("rst_wdata", 64'(avm_if.avm_writedata), 64'd0);
        chk("rst_valid", 64'(evt_valid), 64'd0);
        chk("rst_count", 64'(evt_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd1);
        tick();
        reset_n = 1'b1;
        tick(3);
        @(negedge clk);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_valid", 64'(evt_valid), 64'd0);
        chk("t1_mask_write", 64'(exp_acc.size()), 64'd0);

        // Single edge, service latency
        exp_svc();
        exp_evt.push_back({10'h010, 10'h010});
        tick();
        in_port = 10'h010;
        irq_at = -1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (avm_if.avm_irq && irq_at < 0) irq_at = k;
            if (evt_valid) begin
                lat = k - irq_at;
                break;
            end
        end
        chk("t2_latency", 64'(lat), 64'd8);
        chk("t2_count", 64'(evt_count), 64'd1);
        tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        in_port = '0;
        tick(2);
        @(negedge clk);
        chk("t2_count_after_pop", 64'(evt_count), 64'd0);
        chk("t2_acc_done", 64'(exp_acc.size()), 64'd0);

        // Fill FIFO, fifth irq held until a pop
        for (int i = 0; i < 4; i++) begin
            exp_svc();
            exp_evt.push_back({v3[i], v3[i]});
            tick();
            in_port = v3[i];
            wait_cnt(i + 1);
            tick(3);
            in_port = '0;
            tick(2);
        end
        exp_svc();
        exp_evt.push_back({v3[4], v3[4]});
        in_port = v3[4];
        tick(20);
        @(negedge clk);
        chk("t3_full_count", 64'(evt_count), 64'd4);
        chk("t3_held_no_read", 64'(exp_acc.size()), 64'd3);
        tick();
        evt_ready = 1'b1;
        tick();
        evt_ready = 1'b0;
        wait_acc_empty();
        wait_cnt(4);
        tick();
        evt_ready = 1'b1;
        wait_evt_empty();
        wait_cnt(0);
        tick();
        in_port = '0;
        tick(3);

        // Mask reload during S_WCAP waits for the service
        exp_svc();
        exp_a(2'd2, 1'b0, 32'h001);
        exp_evt.push_back({10'h020, 10'h020});
        in_port = 10'h020;
        tick(4);
        mask_cfg = 10'h001;
        mask_load = 1'b1;
        tick();
        mask_load = 1'b0;
        wait_acc_empty();
        wait_evt_empty();
        tick();
        in_port = '0;
        tick(2);
        in_port = 10'h008;
        tick(20);
        @(negedge clk);
        chk("t4_masked_count", 64'(evt_count), 64'd0);
        chk("t4_masked_busy", 64'(busy), 64'd0);
        chk("t4_acc_done", 64'(exp_acc.size()), 64'd0);

        // Spurious irq with empty edge_capture
        tick();
        model_clr = 1'b1;
        tick();
        model_clr = 1'b0;
        exp_svc();
        irq_force = 1'b1;
        tick();
        irq_force = 1'b0;
        tick(15);
        @(negedge clk);
        chk("t5_count", 64'(evt_count), 64'd0);
        chk("t5_valid", 64'(evt_valid), 64'd0);
        chk("t5_acc_done", 64'(exp_acc.size()), 64'd0);

        // Reset during S_RDLVL
        tick();
        in_port = '0;
        tick(2);
        exp_a(2'd2, 1'b0, 32'h3FF);
        mask_cfg = 10'h3FF;
        mask_load = 1'b1;
        tick();
        mask_load = 1'b0;
        tick(5);
        evt_ready = 1'b0;
        exp_svc();
        in_port = 10'h040;
        wait_cnt(1);
        tick(3);
        exp_a(2'd3, 1'b1, 32'd0);
        in_port = 10'h0C0;
        tick(5);
        reset_n = 1'b0;
        @(negedge clk);
        chk("t6_cs_abort", 64'(avm_if.avm_chipselect), 64'd0);
        chk("t6_fifo_flush", 64'(evt_count), 64'd0);
        chk("t6_valid", 64'(evt_valid), 64'd0);
        chk("t6_busy", 64'(busy), 64'd1);
        chk("t6_acc_before", 64'(exp_acc.size()), 64'd0);
        tick(2);
        exp_a(2'd2, 1'b0, 32'h3FF);
        exp_svc();
        exp_evt.push_back({10'h080, 10'h0C0});
        reset_n = 1'b1;
        tick();
        evt_ready = 1'b1;
        wait_acc_empty();
        wait_evt_empty();
        tick(3);
        @(negedge clk);
        chk("t6_count_end", 64'(evt_count), 64'd0);
        chk("t6_busy_end", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
